// File: rtl/rdr_fifo.sv
// Receive data register backed by a circular FWFT FIFO, with sticky overrun
// and frame-error status for the UART receive path.
module rdr_fifo #(
   parameter int DATA_SIZE  = 7,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  res,
   input  logic [DATA_SIZE-1:0]  d_i,
   input  logic                  data_ready,
   input  logic                  frame_error,
   output logic                  data_read_ack,
   input  logic                  rd_en,
   output logic [DATA_SIZE-1:0]  d_o,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overrun,
   output logic                  frame_err_flag,
   input  logic                  err_clr
);

   // Handshake: data_ready is a one-cycle push strobe with no back-pressure;
   // data_read_ack pulses the cycle after a character is stored. rd_en pops the
   // head only while empty is low; d_o is valid whenever empty is low.
   localparam int                  DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

   logic [DATA_SIZE-1:0]  mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  ack_q, ack_d;
   logic                  overrun_q, overrun_d;
   logic                  ferr_q, ferr_d;
   logic                  push, pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_FULL);

   always_comb begin
      push      = data_ready && !frame_error && !full;
      pop       = rd_en && !empty;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      ack_d     = push;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      // A new error event in the clearing cycle keeps the flag set.
      overrun_d = (overrun_q && !err_clr) || (data_ready && !frame_error && full);
      ferr_d    = (ferr_q && !err_clr) || (data_ready && frame_error);
   end

   always_ff @(posedge clk) begin
      if (res) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ack_q     <= 1'b0;
         overrun_q <= 1'b0;
         ferr_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ack_q     <= ack_d;
         overrun_q <= overrun_d;
         ferr_q    <= ferr_d;
         if (push) mem_q[wr_ptr_q] <= d_i;
      end
   end

   assign d_o            = mem_q[rd_ptr_q];
   assign count          = count_q;
   assign data_read_ack  = ack_q;
   assign overrun        = overrun_q;
   assign frame_err_flag = ferr_q;

endmodule

// File: tb/tb_rdr_fifo.sv
// Self-checking bench for rdr_fifo against a queue-based model of the FIFO
// and its sticky status flags.
module tb_rdr_fifo;

   localparam int DW    = 7;
   localparam int DL2   = 3;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          res = 1'b0;
   logic [DW-1:0] d_i = '0;
   logic          data_ready = 1'b0;
   logic          frame_error = 1'b0;
   logic          data_read_ack;
   logic          rd_en = 1'b0;
   logic [DW-1:0] d_o;
   logic          empty, full;
   logic [DL2:0]  count;
   logic          overrun, frame_err_flag;
   logic          err_clr = 1'b0;

   rdr_fifo #(.DATA_SIZE(DW), .DEPTH_LOG2(DL2)) dut (
      .clk(clk), .res(res), .d_i(d_i), .data_ready(data_ready),
      .frame_error(frame_error), .data_read_ack(data_read_ack), .rd_en(rd_en),
      .d_o(d_o), .empty(empty), .full(full), .count(count), .overrun(overrun),
      .frame_err_flag(frame_err_flag), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   // Reference model
   logic [DW-1:0] exp_q[$];
   logic          m_ack, m_ovr, m_ferr, m_after_reset;
   int            n_pass = 0;
   int            n_total = 0;

   // Apply one cycle of inputs, advance model at the edge, release strobes.
   task automatic drive(input logic dr, input logic fe, input logic [DW-1:0] d,
                        input logic rd, input logic clr, input logic rst);
      bit m_full, m_empty, mpush, mpop;
      data_ready = dr; frame_error = fe; d_i = d; rd_en = rd; err_clr = clr; res = rst;
      @(posedge clk);
      if (rst) begin
         exp_q.delete();
         m_ack = 0; m_ovr = 0; m_ferr = 0; m_after_reset = 1;
      end else begin
         m_full  = (exp_q.size() == DEPTH);
         m_empty = (exp_q.size() == 0);
         mpush   = dr && !fe && !m_full;
         mpop    = rd && !m_empty;
         m_ovr   = (dr && !fe && m_full) || (m_ovr && !clr);
         m_ferr  = (dr && fe) || (m_ferr && !clr);
         m_ack   = mpush;
         if (mpop) void'(exp_q.pop_front());
         if (mpush) begin
            exp_q.push_back(d);
            m_after_reset = 0;
         end
      end
      #1;
      data_ready = 0; frame_error = 0; rd_en = 0; err_clr = 0; res = 0;
   endtask

   task automatic test_reset;
      drive(0, 0, '0, 0, 0, 1);
      n_total++;
      if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || d_o !== 7'h00 ||
          data_read_ack !== 1'b0 || overrun !== 1'b0 || frame_err_flag !== 1'b0)
         $display("FAIL reset: count=%0d empty=%b full=%b d_o=%h ack=%b ovr=%b ferr=%b (want 0 1 0 00 0 0 0)",
                  count, empty, full, d_o, data_read_ack, overrun, frame_err_flag);
      else n_pass++;
   endtask

   task automatic test_three_push;
      logic [DW-1:0] vals[3];
      vals[0] = 7'h11; vals[1] = 7'h22; vals[2] = 7'h33;
      drive(0, 0, '0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, vals[i], 0, 0, 0);
         n_total++;
         if (data_read_ack !== 1'b1 || count !== 4'(i + 1))
            $display("FAIL push3_ack[%0d]: ack=%b count=%0d want ack=1 count=%0d", i, data_read_ack, count, i + 1);
         else n_pass++;
      end
      drive(0, 0, '0, 0, 0, 0);
      n_total++;
      if (data_read_ack !== 1'b0 || count !== 4'd3 || d_o !== 7'h11 || empty !== 1'b0)
         $display("FAIL push3_state: ack=%b count=%0d d_o=%h empty=%b want 0 3 11 0", data_read_ack, count, d_o, empty);
      else n_pass++;
   endtask

   task automatic test_overrun;
      logic [DW-1:0] vals[DEPTH];
      drive(0, 0, '0, 0, 0, 1);
      for (int i = 0; i < DEPTH; i++) begin
         vals[i] = DW'($urandom_range(0, 126));
         drive(1, 0, vals[i], 0, 0, 0);
      end
      n_total++;
      if (full !== 1'b1 || count !== 4'd8 || overrun !== 1'b0)
         $display("FAIL fill: full=%b count=%0d ovr=%b want 1 8 0", full, count, overrun);
      else n_pass++;
      drive(1, 0, 7'h7F, 1, 0, 0);  // same-cycle pop must not rescue it
      n_total++;
      if (data_read_ack !== 1'b0 || overrun !== 1'b1 || count !== 4'd7)
         $display("FAIL ovr_push: ack=%b ovr=%b count=%0d want 0 1 7", data_read_ack, overrun, count);
      else n_pass++;
      for (int i = 1; i < DEPTH; i++) begin
         n_total++;
         if (d_o !== vals[i]) $display("FAIL drain[%0d]: d_o=%h want %h", i, d_o, vals[i]);
         else n_pass++;
         drive(0, 0, '0, 1, 0, 0);
      end
      n_total++;
      if (empty !== 1'b1 || count !== 4'd0 || overrun !== 1'b1)
         $display("FAIL drained: empty=%b count=%0d ovr=%b want 1 0 1", empty, count, overrun);
      else n_pass++;
   endtask

   task automatic test_frame_err;
      drive(0, 0, '0, 0, 0, 1);
      drive(1, 0, 7'h01, 0, 0, 0);
      drive(1, 1, 7'h55, 0, 0, 0);
      n_total++;
      if (count !== 4'd1 || data_read_ack !== 1'b0 || frame_err_flag !== 1'b1 || d_o !== 7'h01)
         $display("FAIL ferr_set: count=%0d ack=%b ferr=%b d_o=%h want 1 0 1 01", count, data_read_ack, frame_err_flag, d_o);
      else n_pass++;
      drive(0, 0, '0, 0, 1, 0);
      n_total++;
      if (frame_err_flag !== 1'b0) $display("FAIL ferr_clr: ferr=%b want 0", frame_err_flag);
      else n_pass++;
      drive(1, 1, 7'h55, 0, 1, 0);
      n_total++;
      if (frame_err_flag !== 1'b1) $display("FAIL ferr_set_wins: ferr=%b want 1", frame_err_flag);
      else n_pass++;
   endtask

   task automatic test_back_to_back;
      logic [DW-1:0] nxt, exp_head;
      drive(0, 0, '0, 0, 0, 1);
      for (int i = 0; i < 4; i++) drive(1, 0, DW'(i), 0, 0, 0);
      nxt = 7'd4;
      exp_head = 7'd0;
      for (int i = 0; i < 20; i++) begin
         n_total++;
         if (d_o !== exp_head) $display("FAIL b2b_head[%0d]: d_o=%h want %h", i, d_o, exp_head);
         else n_pass++;
         drive(1, 0, nxt, 1, 0, 0);
         nxt++;
         exp_head++;
         n_total++;
         if (count !== 4'd4 || data_read_ack !== 1'b1)
            $display("FAIL b2b_count[%0d]: count=%0d ack=%b want 4 1", i, count, data_read_ack);
         else n_pass++;
      end
   endtask

   task automatic test_empty_pop;
      drive(0, 0, '0, 0, 0, 1);
      for (int i = 0; i < 3; i++) drive(0, 0, '0, 1, 0, 0);
      n_total++;
      if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0)
         $display("FAIL empty_pop: count=%0d empty=%b full=%b want 0 1 0", count, empty, full);
      else n_pass++;
      drive(1, 0, 7'h2A, 0, 0, 0);
      n_total++;
      if (d_o !== 7'h2A || count !== 4'd1)
         $display("FAIL empty_pop_ptr: d_o=%h count=%0d want 2a 1", d_o, count);
      else n_pass++;
   endtask

   task automatic test_reset_mid;
      drive(0, 0, '0, 0, 0, 1);
      for (int i = 0; i < DEPTH + 1; i++) drive(1, 0, DW'(8'h40 + i), 0, 0, 0);
      for (int i = 0; i < 3; i++) drive(0, 0, '0, 1, 0, 0);
      n_total++;
      if (count !== 4'd5 || overrun !== 1'b1)
         $display("FAIL pre_reset: count=%0d ovr=%b want 5 1", count, overrun);
      else n_pass++;
      drive(1, 0, 7'h66, 1, 0, 1);
      n_total++;
      if (count !== 4'd0 || empty !== 1'b1 || overrun !== 1'b0 || frame_err_flag !== 1'b0 ||
          data_read_ack !== 1'b0 || d_o !== 7'h00)
         $display("FAIL reset_mid: count=%0d empty=%b ovr=%b ferr=%b ack=%b d_o=%h want 0 1 0 0 0 00",
                  count, empty, overrun, frame_err_flag, data_read_ack, d_o);
      else n_pass++;
   endtask

   task automatic test_random;
      int bad;
      logic [DW-1:0] exp_do;
      drive(0, 0, '0, 0, 0, 1);
      bad = 0;
      for (int i = 0; i < 400; i++) begin
         // Alternate fill-biased and drain-biased phases to reach both ends.
         int pw = ((i / 50) % 2 == 0) ? 75 : 30;
         drive($urandom_range(0, 99) < pw, $urandom_range(0, 7) == 0, DW'($urandom),
               $urandom_range(0, 99) < (100 - pw), $urandom_range(0, 15) == 0, 0);
         exp_do = (exp_q.size() != 0) ? exp_q[0] : (m_after_reset ? 7'h00 : d_o);
         n_total++;
         if (count !== 4'(exp_q.size()) || empty !== (exp_q.size() == 0) ||
             full !== (exp_q.size() == DEPTH) || data_read_ack !== m_ack ||
             overrun !== m_ovr || frame_err_flag !== m_ferr || d_o !== exp_do) begin
            if (bad < 10)
               $display("FAIL random[%0d]: count=%0d/%0d ack=%b/%b ovr=%b/%b ferr=%b/%b d_o=%h/%h (got/want)",
                        i, count, exp_q.size(), data_read_ack, m_ack, overrun, m_ovr,
                        frame_err_flag, m_ferr, d_o, exp_do);
            bad++;
         end else n_pass++;
      end
   endtask

   initial begin
      m_ack = 0; m_ovr = 0; m_ferr = 0; m_after_reset = 1;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_three_push();
      test_overrun();
      test_frame_err();
      test_back_to_back();
      test_empty_pop();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
